// File: rtl/lutram_fifo_pkg.sv
// rtl/lutram_fifo_pkg.sv - shared sizes and pointer flag helper for lutram_fifo
package lutram_fifo_pkg;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int LVL_W  = 8;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // addresses with differing wrap bits mean a whole lap ahead, i.e. full.
  function automatic fifo_flags_t ptr_flags(input logic [PTR_W-1:0] wr_ptr,
                                            input logic [PTR_W-1:0] rd_ptr);
    fifo_flags_t f;
    f.empty = (wr_ptr == rd_ptr);
    f.full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
              (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    return f;
  endfunction

endpackage

// File: rtl/RAM128X1D.sv
// rtl/RAM128X1D.sv - behavioural model of the 128x1 dual-port LUT-RAM primitive
module RAM128X1D (
  input  logic       WCLK,
  input  logic       WE,
  input  logic [6:0] A,
  input  logic       D,
  input  logic [6:0] DPRA,
  output logic       SPO,
  output logic       DPO
);

  logic mem [128];

  // Synchronous write through port A; both read ports are asynchronous.
  always_ff @(posedge WCLK) begin
    if (WE) mem[A] <= D;
  end

  assign SPO = mem[A];
  assign DPO = mem[DPRA];

endmodule

// File: rtl/lutram_fifo_mem.sv
// rtl/lutram_fifo_mem.sv - WIDTH-bit storage built from RAM128X1D bit slices
module lutram_fifo_mem
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              WCLK,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [ADDR_W-1:0] DPRA,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  DPO
);

  // The write-address read port has no consumer in the FIFO.
  logic [WIDTH-1:0] spo_unused;

  // One primitive per data bit, all sharing the write port and read address.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    RAM128X1D u_ram (
      .WCLK (WCLK),
      .WE   (WE),
      .A    (A),
      .D    (D[i]),
      .DPRA (DPRA),
      .SPO  (spo_unused[i]),
      .DPO  (DPO[i])
    );
  end

endmodule

// File: rtl/lutram_fifo.sv
// rtl/lutram_fifo.sv - 128-deep LUT-RAM FIFO; LUTRAM_FIFO_FWFT_EN selects first-word fall-through
module lutram_fifo
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int INIT_LEVEL_CHK = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             FULL,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             EMPTY,
  output logic [LVL_W-1:0] LEVEL,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  fifo_flags_t      flags;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] dpo;

  assign flags  = ptr_flags(wr_ptr, rd_ptr);
  assign FULL   = flags.full;
  assign EMPTY  = flags.empty;
  assign LEVEL  = LVL_W'(wr_ptr - rd_ptr);
  assign wr_acc = WR_EN & ~flags.full;
  assign rd_acc = RD_EN & ~flags.empty;

  // Reset must never corrupt stored words, so the RAM write is gated by RST.
  lutram_fifo_mem #(.WIDTH(WIDTH)) u_mem (
    .WCLK (CLK),
    .WE   (wr_acc & ~RST),
    .A    (wr_ptr[ADDR_W-1:0]),
    .DPRA (rd_ptr[ADDR_W-1:0]),
    .D    (WR_DATA),
    .DPO  (dpo)
  );

  // Pointer advance on accepted accesses; reset empties the FIFO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  if (INIT_LEVEL_CHK != 0) begin : g_chk
    // One-cycle pulses flagging requests rejected at the previous edge.
    always_ff @(posedge CLK) begin
      if (RST) begin
        OVERFLOW  <= 1'b0;
        UNDERFLOW <= 1'b0;
      end else begin
        OVERFLOW  <= WR_EN & flags.full;
        UNDERFLOW <= RD_EN & flags.empty;
      end
    end
  end else begin : g_no_chk
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
  end

`ifdef LUTRAM_FIFO_FWFT_EN
  // Head word is presented directly; RD_EN only acknowledges it.
  assign RD_DATA  = dpo;
  assign RD_VALID = ~flags.empty;
`else
  // Registered pop: data appears one cycle after an accepted read and holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= rd_acc;
      if (rd_acc) RD_DATA <= dpo;
    end
  end
`endif

endmodule

// File: tb/tb_lutram_fifo.sv
// tb/tb_lutram_fifo.sv - randomized and directed check of lutram_fifo against a queue model
module tb_lutram_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       FULL;
  logic       RD_EN;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic       EMPTY;
  logic [7:0] LEVEL;
  logic       OVERFLOW;
  logic       UNDERFLOW;

  int checks = 0;
  int errors = 0;

  // Reference state: the stored words in order, plus the expected read port.
  logic [7:0] q[$];
  logic       exp_valid;
  logic [7:0] exp_data;
  logic       exp_ovf;
  logic       exp_unf;

  always #5 CLK = ~CLK;

  lutram_fifo #(.WIDTH(8), .INIT_LEVEL_CHK(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_EN     (WR_EN),
    .WR_DATA   (WR_DATA),
    .FULL      (FULL),
    .RD_EN     (RD_EN),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .EMPTY     (EMPTY),
    .LEVEL     (LEVEL),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic wr, input logic [7:0] d, input logic rd);
    int n;
    if (rst) begin
      q.delete();
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      n       = q.size();
      exp_ovf = wr && (n == 128);
      exp_unf = rd && (n == 0);
`ifndef LUTRAM_FIFO_FWFT_EN
      exp_valid = 1'b0;
`endif
      if (rd && n != 0) begin
`ifdef LUTRAM_FIFO_FWFT_EN
        void'(q.pop_front());
`else
        exp_data  = q.pop_front();
        exp_valid = 1'b1;
`endif
      end
      if (wr && n != 128) q.push_back(d);
    end
  endtask

  task automatic compare();
    chk("level", 32'(LEVEL), 32'(q.size()));
    chk("empty", 32'(EMPTY), 32'(q.size() == 0));
    chk("full", 32'(FULL), 32'(q.size() == 128));
    chk("overflow", 32'(OVERFLOW), 32'(exp_ovf));
    chk("underflow", 32'(UNDERFLOW), 32'(exp_unf));
`ifdef LUTRAM_FIFO_FWFT_EN
    chk("rd_valid", 32'(RD_VALID), 32'(q.size() != 0));
    if (q.size() != 0) chk("rd_data", 32'(RD_DATA), 32'(q[0]));
`else
    chk("rd_valid", 32'(RD_VALID), 32'(exp_valid));
    chk("rd_data", 32'(RD_DATA), 32'(exp_data));
`endif
  endtask

  // Drive at the falling edge, update the model on the rising edge, compare
  // at the following falling edge.
  task automatic cycle(input logic rst, input logic wr, input logic [7:0] d, input logic rd);
    RST     = rst;
    WR_EN   = wr;
    WR_DATA = d;
    RD_EN   = rd;
    @(posedge CLK);
    model(rst, wr, d, rd);
    @(negedge CLK);
    compare();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] cnt;
    int pw[4] = '{80, 20, 50, 95};
    int pr[4] = '{20, 80, 50, 95};

    RST = 1'b1; WR_EN = 1'b0; WR_DATA = 8'h00; RD_EN = 1'b0;
    @(negedge CLK);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Idle after reset, then a read while empty.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Fill to 128, one rejected write, drain.
    for (int i = 0; i < 128; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 1'b1, 8'hAB, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 130; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Steady push/pop at level 5 across several pointer wraps.
    cnt = 8'h00;
    for (int i = 0; i < 5; i++) begin cycle(1'b0, 1'b1, cnt, 1'b0); cnt++; end
    for (int i = 0; i < 300; i++) begin cycle(1'b0, 1'b1, cnt, 1'b1); cnt++; end

    // Reset mid-stream with a write pending, then a single round trip.
    for (int i = 0; i < 35; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Write into empty then acknowledge: exercises fall-through latency too.
    cycle(1'b0, 1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized traffic with varying bias and occasional resets.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 600; i++) begin
        cycle(($urandom_range(299) == 0),
              ($urandom_range(99) < pw[p]),
              8'($urandom),
              ($urandom_range(99) < pr[p]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
